// File: rtl/addtk_stage.sv
// ---------------------------------------------------------------------------
// addtk_stage
//   Round-entry stage of the QARMAv2-128 iterative core. It XORs the current
//   128-bit state with the round tweakey, registers the result and offers it
//   to the S-box layer over a valid/ready handshake. The stage owns the round
//   counter. It loads a fresh block from in_state, and reloads from fb_state
//   on every later round. The last round is flagged with out_last.
//
// Parameters
//   ROUNDS      number of round issues per block (2..15)
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   in_valid    new block offered
//   in_ready    block accepted (high only while idle)
//   in_state    new block state, nibble i = bits [4i+3:4i]
//   tk_idx      index of the tweakey needed at the next capture
//   tk          round tweakey for tk_idx (combinational from key schedule)
//   fb_valid    single-cycle pulse, fb_state holds the rest-of-round result
//   fb_state    state returned from the linear layer
//   out_valid   out_state is valid for the S-box layer
//   out_ready   downstream accepts out_state
//   out_state   registered state ^ tk
//   out_round   round index of the issued out_state
//   out_last    high with out_valid on the final round
//   busy        high whenever a block is in flight
//
// Configuration
//   ADDTK_ZEROIZE_EN  when defined, out_state/out_round/out_last are cleared
//                     on the final handshake, so no key-dependent data stays
//                     in the register while idle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module addtk_stage #(
  parameter int ROUNDS = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic [3:0]   tk_idx,
  input  logic [127:0] tk,
  input  logic         fb_valid,
  input  logic [127:0] fb_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_FB = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t     st;
  logic [3:0] next_round;

  assign next_round = out_round + 4'd1;

  // NOTE: every register here, including the 128-bit data path, is cleared by
  // the async reset so an aborted block leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      out_valid <= 1'b0;
      out_state <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order.
      case (st)
        IDLE: begin
          if (in_valid) begin
            out_state <= in_state ^ tk;
            out_round <= '0;
            out_last  <= (LAST_ROUND == 4'd0);
            out_valid <= 1'b1;
            st        <= ISSUE;
          end
        end

        ISSUE: begin
          // Outputs are held until the S-box layer takes them; fb_valid is
          // deliberately not looked at here.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_round == LAST_ROUND) begin
              st <= IDLE;
`ifdef ADDTK_ZEROIZE_EN
              out_state <= '0;
              out_round <= '0;
              out_last  <= 1'b0;
`endif
            end else begin
              st <= WAIT_FB;
            end
          end
        end

        WAIT_FB: begin
          if (fb_valid) begin
            out_state <= fb_state ^ tk;
            out_round <= next_round;
            out_last  <= (next_round == LAST_ROUND);
            out_valid <= 1'b1;
            st        <= ISSUE;
          end
        end

        default: begin
          st        <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (st == IDLE);
  assign busy     = (st != IDLE);

  // The key schedule is asked for the tweakey of the next capture: round 0
  // when idle, otherwise the round after the one currently issued.
  // NOTE: a default assignment first keeps this block free of latches.
  always_comb begin
    tk_idx = 4'd0;
    case (st)
      ISSUE:   tk_idx = (out_round == LAST_ROUND) ? 4'd0 : next_round;
      WAIT_FB: tk_idx = next_round;
      default: tk_idx = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_addtk_stage.sv
// ---------------------------------------------------------------------------
// tb_addtk_stage
//   Self-checking bench for addtk_stage. A bench-side key schedule drives tk
//   from a table indexed by tk_idx. The expected round values are computed
//   arithmetically:
//     s0 = block ^ key[0]
//     s(r+1) = (s(r) + 1) ^ key[r+1]
//   The rest of the round is modelled as fb_state = issued state + 1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_addtk_stage;

  localparam int R = 13;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [3:0]   tk_idx;
  logic [127:0] tk;
  logic         fb_valid;
  logic [127:0] fb_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_last;
  logic         busy;

  logic [127:0] key_tab [16];

  int tests;
  int errors;

  addtk_stage #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .tk_idx    (tk_idx),
    .tk        (tk),
    .fb_valid  (fb_valid),
    .fb_state  (fb_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb tk = key_tab[tk_idx];

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_keys(input bit zero);
    for (int i = 0; i < 16; i++) key_tab[i] = zero ? '0 : rand128();
  endtask

  // Drives one whole block from IDLE and checks every issue against the
  // arithmetic model. Stimulus changes and sampling happen on negedges.
  task automatic run_block(input logic [127:0] blk, input bit rnd,
                           input bit hold, input logic [127:0] nxt,
                           output int hs, output int cyc);
    logic [127:0] exp;
    int k;
    hs  = 0;
    cyc = 0;
    tests++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL in_ready_idle: got %b expected 1", in_ready);
    end
    in_state = blk;
    in_valid = 1'b1;
    @(negedge clk); cyc++;
    if (hold) in_state = nxt; else in_valid = 1'b0;
    exp = blk ^ key_tab[0];
    for (int r = 0; r < R; r++) begin
      k = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int s = 0; s < k; s++) begin
        out_ready = 1'b0;
        fb_valid  = 1'($urandom_range(0, 1));
        fb_state  = rand128();
        @(negedge clk); cyc++;
        tests++;
        if (out_state !== exp || out_round !== 4'(r) || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold r=%0d: got %h/%0d/%b expected %h/%0d/1",
                   r, out_state, out_round, out_valid, exp, r);
        end
      end
      fb_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_state !== exp || out_round !== 4'(r) ||
          out_last !== (r == R - 1) || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL issue r=%0d: got v%b %h rnd%0d last%b busy%b rdy%b expected v1 %h rnd%0d last%b busy1 rdy0",
                 r, out_valid, out_state, out_round, out_last, busy, in_ready,
                 exp, r, (r == R - 1));
      end
      out_ready = 1'b1;
      @(negedge clk); cyc++; hs++;
      out_ready = 1'b0;
      if (r == R - 1) break;
      k = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int s = 0; s < k; s++) begin
        @(negedge clk); cyc++;
      end
      tests++;
      if (out_valid !== 1'b0 || tk_idx !== 4'(r + 1) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL wait_fb r=%0d: got v%b idx%0d rdy%b expected v0 idx%0d rdy0",
                 r, out_valid, tk_idx, in_ready, r + 1);
      end
      fb_state = exp + 128'd1;
      fb_valid = 1'b1;
      @(negedge clk); cyc++;
      fb_valid = 1'b0;
      exp = (exp + 128'd1) ^ key_tab[r + 1];
    end
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || tk_idx !== 4'd0) begin
      errors++;
      $display("FAIL end_idle: got v%b busy%b rdy%b idx%0d expected v0 busy0 rdy1 idx0",
               out_valid, busy, in_ready, tk_idx);
    end
    tests++;
`ifdef ADDTK_ZEROIZE_EN
    if (out_state !== '0 || out_round !== 4'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL zeroize: got %h/%0d/%b expected 0/0/0", out_state, out_round, out_last);
    end
`else
    if (out_state !== exp || out_round !== 4'(R - 1) || out_last !== 1'b1) begin
      errors++;
      $display("FAIL hold_after: got %h/%0d/%b expected %h/%0d/1",
               out_state, out_round, out_last, exp, R - 1);
    end
`endif
  endtask

  task automatic check_reset_values(input string tag);
    tests++;
    if (out_valid !== 1'b0 || out_state !== '0 || out_round !== 4'd0 ||
        out_last !== 1'b0 || busy !== 1'b0 || tk_idx !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: got v%b %h rnd%0d last%b busy%b idx%0d rdy%b expected all zero, rdy1",
               tag, out_valid, out_state, out_round, out_last, busy, tk_idx, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; fb_valid = 1'b0;
    fb_state = '0; out_ready = 1'b0;
    set_keys(1'b0);
    #1;
    check_reset_values("reset_por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_release");
  endtask

  // Leaves the stage in ISSUE holding a nonzero value for test_reset_mid.
  task automatic test_single_round();
    key_tab[0] = '1;
    in_state   = 128'h0123456789abcdef0123456789abcdef;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_state !== 128'hfedcba9876543210fedcba9876543210 || out_round !== 4'd0 ||
        out_valid !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL single_round: got %h/%0d/v%b/l%b expected fedcba9876543210fedcba9876543210/0/v1/l0",
               out_state, out_round, out_valid, out_last);
    end
  endtask

  task automatic test_reset_mid();
    tests++;
    if (out_state === '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got %h busy%b expected nonzero busy1", out_state, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_values("reset_mid_idle");
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [127:0] blk, exp;
    set_keys(1'b0);
    blk = rand128();
    exp = blk ^ key_tab[0];
    in_state = blk; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    fb_valid = 1'b1; fb_state = rand128();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (out_state !== exp || out_round !== 4'd0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure c%0d: got %h/%0d/v%b expected %h/0/v1",
                 i, out_state, out_round, out_valid, exp);
      end
    end
    fb_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || tk_idx !== 4'd1) begin
      errors++;
      $display("FAIL bp_no_advance: got v%b idx%0d expected v0 idx1", out_valid, tk_idx);
    end
    fb_state = exp + 128'd1; fb_valid = 1'b1;
    @(negedge clk);
    fb_valid = 1'b0;
    tests++;
    if (out_state !== ((exp + 128'd1) ^ key_tab[1]) || out_round !== 4'd1) begin
      errors++;
      $display("FAIL bp_round1: got %h/%0d expected %h/1",
               out_state, out_round, (exp + 128'd1) ^ key_tab[1]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_block();
    int hs, cyc;
    set_keys(1'b1);
    run_block(rand128(), 1'b0, 1'b0, '0, hs, cyc);
    tests++;
    if (hs !== R) begin
      errors++; $display("FAIL full_handshakes: got %0d expected %0d", hs, R);
    end
    tests++;
    if (cyc !== 2 * R) begin
      errors++; $display("FAIL full_latency: got %0d expected %0d", cyc, 2 * R);
    end
  endtask

  task automatic test_busy_lockout();
    int hs, cyc;
    logic [127:0] b;
    set_keys(1'b0);
    b = rand128();
    run_block(rand128(), 1'b0, 1'b1, b, hs, cyc);
    // in_valid is still high here; run_block captures b on the next edge.
    run_block(b, 1'b0, 1'b0, '0, hs, cyc);
    tests++;
    if (hs !== R) begin
      errors++; $display("FAIL lockout_second: got %0d expected %0d", hs, R);
    end
  endtask

  task automatic test_idle_fb();
    for (int i = 0; i < 3; i++) begin
      fb_valid = 1'b1; fb_state = rand128();
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_fb c%0d: got v%b busy%b expected v0 busy0", i, out_valid, busy);
      end
    end
    fb_valid = 1'b0;
  endtask

  task automatic test_random_blocks();
    int hs, cyc;
    for (int n = 0; n < 4; n++) begin
      set_keys(1'b0);
      run_block(rand128(), 1'b1, 1'b0, '0, hs, cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    test_reset();
    test_single_round();
    test_reset_mid();
    test_backpressure();
    test_full_block();
    test_busy_lockout();
    test_idle_fb();
    test_random_blocks();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
